fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO (winc/wdata/wfull, write-clock domain) between NREQ requesters.
- Grants one requester at a time for a burst of up to BURST words, stalls cleanly on wfull, then rotates priority.
- Sits entirely in the write clock domain, directly in front of the FIFO write port.

Parameters:
- DSIZE, 8: data word width; equals the FIFO DSIZE.
- NREQ, 4: number of requesters, >= 2.
- BURST, 4: maximum words written per grant, >= 1.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; bit i high = requester i has a word on its req_data slice.
- req_data  input  NREQ*DSIZE  packed data; slice i = bits [i*DSIZE +: DSIZE].
- gnt  output  NREQ  registered one-hot grant; all-zero when idle.
- ack  output  NREQ  per-requester word-accepted strobe, combinational.
- owner_id  output  clog2(NREQ)  registered index of the current owner; holds last value when idle.
- busy  output  1  registered; high while in GRANT.
- winc  output  1  FIFO write enable, combinational.
- wdata  output  DSIZE  FIFO write data = req_data slice owner_id.
- wfull  input  1  FIFO full flag from the write-pointer logic.

Behaviour:
- Clocking: one clock (wclk); asynchronous active-low reset (wrst_n). All state flops are reset asynchronously and clocked on the rising edge of wclk.
- Reset values: state=IDLE, gnt=0, busy=0, owner_id=0, rr_ptr=0, burst_cnt=0. Therefore winc=0 and ack=0.
- State registers:
  - 2-state FSM.
  - rr_ptr: clog2(NREQ) bits; the highest-priority index.
  - burst_cnt: clog2(BURST+1) bits.
- IDLE:
  - If any req bit is high, select the first set bit searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Next edge: gnt=onehot(sel), owner_id=sel, busy=1, burst_cnt=0, state=GRANT.
  - If req is all-zero, remain in IDLE.
  - IDLE always lasts at least 1 cycle between grants.
- GRANT, combinational outputs:
  - winc = busy & req[owner_id] & ~wfull.
  - ack[owner_id] = winc; all other ack bits are 0.
  - wdata = req_data slice owner_id in all states; it is don't-care when winc=0.
- GRANT, per edge:
  - If winc: burst_cnt += 1.
  - Release when (winc and burst_cnt==BURST-1) or req[owner_id]==0.
  - On release: state=IDLE, gnt=0, busy=0, burst_cnt=0, rr_ptr=(owner_id+1) mod NREQ. owner_id keeps its value.
  - Otherwise hold grant and count.
- wfull stall: winc held 0; burst_cnt and grant held; no timeout. The grant persists until wfull drops or the owner drops req.
- Requester protocol:
  - req and req_data must stay stable until ack is seen.
  - After ack, the requester presents its next word in the following cycle or drops req.
  - Non-owner req bits are ignored and never acked.
- Simultaneous events:
  - wfull=1 and owner req=0 in the same cycle: release; no write.
  - Final burst word while other requests are pending: release, then 1 IDLE cycle, then arbitration from the new rr_ptr.
- Reset mid-operation: all outputs drop asynchronously at the wrst_n falling edge. Any partially written burst is abandoned; words already written stay in the FIFO.
- Width/wrap: rr_ptr wraps from NREQ-1 to 0. burst_cnt never exceeds BURST-1 while in GRANT.
- Throughput: at most 1 word per cycle. Up to BURST words per grant, followed by 1 IDLE cycle.

Test Plan:
1. Defaults, req[1] held for 6 words, wfull=0:
   - Response: gnt=4'b0010 one cycle after req.
   - 4 consecutive winc/ack[1], with wdata matching the slice.
   - gnt=0 for 1 cycle, regrant.
   - 2 more writes, then release when req[1] drops.
2. req=4'b1111 held continuously:
   - Grant order 0,1,2,3,0.
   - Exactly 4 writes each.
   - 1 IDLE cycle between grants; owner_id sequence 0,1,2,3,0.
3. Requester 2 granted, wfull=1 for 3 cycles after its 2nd write:
   - winc=0 and ack=0 for those 3 cycles; gnt stays 4'b0100.
   - The remaining 2 writes complete after wfull drops; total 4.
4. Requester 0 drops req after 1 ack while req[3]=1:
   - Release, 1 IDLE cycle.
   - gnt=4'b1000 (rr_ptr=1, search 1,2,3 finds 3).
   - Requester 3 writes its burst.
5. wrst_n asserted mid-burst (burst_cnt=2):
   - gnt, busy, winc, ack are 0 immediately and asynchronously.
   - After release, req=4'b0110 grants requester 1 first (rr_ptr reset to 0).
6. wfull=1 at grant time with req[0]=1:
   - Grant issued, winc never asserts; FIFO write pointer unchanged.
   - When wfull falls, the first write occurs that same cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Each grant covers up to BURST words. A grant stalls on wfull and then priority rotates.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  owner_id,
  output logic                     busy,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  input  logic                     wfull
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [OW-1:0]   owner_n;
  logic            busy_n;
  logic [OW-1:0]   rr_ptr, rr_ptr_n;
  logic [CW-1:0]   burst_cnt, burst_cnt_n;

  logic            owner_req;
  logic            sel_found;
  logic [OW-1:0]   sel_idx;
  logic [NREQ-1:0] sel_onehot;
  logic            release_c;

  // Route the owner's request bit and data slice to the FIFO side
  always_comb begin
    owner_req = 1'b0;
    wdata     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_id == OW'(i)) begin
        owner_req = req[i];
        wdata     = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // Write strobe and per-requester acknowledge. Gating by busy clears both at reset.
  always_comb begin
    winc = busy & owner_req & ~wfull;
    ack  = gnt & {NREQ{winc}};
  end

  // Round-robin search starting at rr_ptr. Iterating from the farthest offset lets the nearest win.
  always_comb begin
    int unsigned off;
    int unsigned idx;
    off        = 0;
    idx        = 0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      off = NREQ - 1 - k;
      idx = (32'(rr_ptr) + off) % NREQ;
      if (req[OW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = OW'(idx);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      sel_onehot[i] = sel_found && (sel_idx == OW'(i));
    end
  end

  // Release on the final burst word or when the owner withdraws its request
  always_comb begin
    release_c = (winc && (burst_cnt == CW'(BURST - 1))) || !owner_req;
  end

  // Next-state and next-register values
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    owner_n     = owner_id;
    busy_n      = busy;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_n     = GRANT;
          gnt_n       = sel_onehot;
          owner_n     = sel_idx;
          busy_n      = 1'b1;
          burst_cnt_n = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_n     = IDLE;
          gnt_n       = '0;
          busy_n      = 1'b0;
          burst_cnt_n = '0;
          rr_ptr_n    = (owner_id == OW'(NREQ - 1)) ? '0 : owner_id + OW'(1);
        end else if (winc) begin
          burst_cnt_n = burst_cnt + CW'(1);
        end
      end
      default: begin
        state_n     = IDLE;
        gnt_n       = '0;
        busy_n      = 1'b0;
        burst_cnt_n = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      owner_id  <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      owner_id  <= owner_n;
      busy      <= busy_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with directed requester scenarios.
module tb_fifo_wr_arbiter;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 4;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [1:0]            owner_id;
  logic                  busy;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;

  typedef struct packed {
    logic [NREQ-1:0]  ack;
    logic [DSIZE-1:0] data;
  } exp_t;

  exp_t             expq[$];
  exp_t             mon_e;
  logic [DSIZE-1:0] wmem [NREQ][16];
  int               wcnt [NREQ];
  int               wptr [NREQ];
  logic [NREQ-1:0]  ack_seen;
  int               errors;
  int               checks;
  int               order [5];

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .owner_id (owner_id),
    .busy     (busy),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Monitor: every FIFO write must match the head of the expected queue
  always @(negedge wclk) begin
    if (!wrst_n) begin
      ack_seen = '0;
    end else begin
      ack_seen = ack;
      if (winc) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: ack=%b wdata=%0h with empty queue at %0t", ack, wdata, $time);
        end else begin
          mon_e = expq.pop_front();
          chk("write_ack", 32'(ack), 32'(mon_e.ack));
          chk("write_data", 32'(wdata), 32'(mon_e.data));
          chk("write_gnt", 32'(gnt), 32'(mon_e.ack));
        end
      end else begin
        chk("ack_without_winc", 32'(ack), 32'd0);
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (wptr[i] < wcnt[i]);
      req_data[i*DSIZE +: DSIZE] = (wptr[i] < wcnt[i]) ? wmem[i][wptr[i]] : 8'h00;
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_seen[i]) wptr[i]++;
    end
    drive();
  endtask

  task automatic load(input int r, input int n, input logic [DSIZE-1:0] base);
    wcnt[r] = n;
    wptr[r] = 0;
    for (int k = 0; k < n; k++) wmem[r][k] = base + DSIZE'(k);
  endtask

  task automatic expect_w(input int r, input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ack    = '0;
      e.ack[r] = 1'b1;
      e.data   = wmem[r][first + k];
      expq.push_back(e);
    end
  endtask

  task automatic chk_grant(input string name, input logic [NREQ-1:0] g, input logic b, input logic [1:0] o);
    chk({name, "_gnt"}, 32'(gnt), 32'(g));
    chk({name, "_busy"}, 32'(busy), 32'(b));
    chk({name, "_owner"}, 32'(owner_id), 32'(o));
  endtask

  task automatic do_reset(input string name);
    wrst_n = 1'b0;
    #1;
    chk({name, "_rst_gnt"}, 32'(gnt), 32'd0);
    chk({name, "_rst_busy"}, 32'(busy), 32'd0);
    chk({name, "_rst_owner"}, 32'(owner_id), 32'd0);
    chk({name, "_rst_winc"}, 32'(winc), 32'd0);
    chk({name, "_rst_ack"}, 32'(ack), 32'd0);
    expq.delete();
    for (int i = 0; i < NREQ; i++) begin
      wcnt[i] = 0;
      wptr[i] = 0;
    end
    wfull = 1'b0;
    drive();
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    wrst_n   = 1'b0;
    wfull    = 1'b0;
    req      = '0;
    req_data = '0;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int i = 0; i < NREQ; i++) begin
      wcnt[i] = 0;
      wptr[i] = 0;
    end
    #12;

    // 1: single requester, 6 words -> burst of 4, idle, burst of 2
    do_reset("t1");
    load(1, 6, 8'h10);
    expect_w(1, 0, 6);
    drive();
    step();
    chk_grant("t1_grant", 4'b0010, 1'b1, 2'd1);
    repeat (4) step();
    chk_grant("t1_idle", 4'b0000, 1'b0, 2'd1);
    chk("t1_idle_winc", 32'(winc), 32'd0);
    step();
    chk_grant("t1_regrant", 4'b0010, 1'b1, 2'd1);
    step();
    step();
    chk_grant("t1_hold_after_last", 4'b0010, 1'b1, 2'd1);
    step();
    chk_grant("t1_release", 4'b0000, 1'b0, 2'd1);
    chk("t1_drain", 32'(expq.size()), 32'd0);

    // 2: all requesting -> owners 0,1,2,3,0 with 4 words each
    do_reset("t2");
    for (int r = 0; r < NREQ; r++) load(r, 8, DSIZE'(8'h20 + 8'(r * 16)));
    expect_w(0, 0, 4);
    expect_w(1, 0, 4);
    expect_w(2, 0, 4);
    expect_w(3, 0, 4);
    expect_w(0, 4, 4);
    drive();
    for (int g = 0; g < 5; g++) begin
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[order[g]] = 1'b1;
      step();
      chk_grant("t2_grant", oh, 1'b1, 2'(order[g]));
      repeat (4) step();
      chk_grant("t2_idle", 4'b0000, 1'b0, 2'(order[g]));
    end
    chk("t2_drain", 32'(expq.size()), 32'd0);

    // 3: wfull stall for 3 cycles after the 2nd write of requester 2
    do_reset("t3");
    load(2, 4, 8'h30);
    expect_w(2, 0, 4);
    drive();
    step();
    chk_grant("t3_grant", 4'b0100, 1'b1, 2'd2);
    step();
    step();
    wfull = 1'b1;
    #1;
    chk("t3_stall_winc", 32'(winc), 32'd0);
    chk("t3_stall_ack", 32'(ack), 32'd0);
    step();
    chk_grant("t3_stall1", 4'b0100, 1'b1, 2'd2);
    chk("t3_stall1_winc", 32'(winc), 32'd0);
    step();
    chk_grant("t3_stall2", 4'b0100, 1'b1, 2'd2);
    chk("t3_stall2_winc", 32'(winc), 32'd0);
    step();
    wfull = 1'b0;
    #1;
    chk("t3_resume_winc", 32'(winc), 32'd1);
    step();
    step();
    chk_grant("t3_release", 4'b0000, 1'b0, 2'd2);
    chk("t3_drain", 32'(expq.size()), 32'd0);

    // 4: requester 0 quits after one word, requester 3 wins next
    do_reset("t4");
    load(0, 1, 8'h40);
    load(3, 4, 8'h80);
    expect_w(0, 0, 1);
    expect_w(3, 0, 4);
    drive();
    step();
    chk_grant("t4_grant0", 4'b0001, 1'b1, 2'd0);
    step();
    chk_grant("t4_hold0", 4'b0001, 1'b1, 2'd0);
    step();
    chk_grant("t4_release0", 4'b0000, 1'b0, 2'd0);
    step();
    chk_grant("t4_grant3", 4'b1000, 1'b1, 2'd3);
    repeat (4) step();
    chk_grant("t4_release3", 4'b0000, 1'b0, 2'd3);
    chk("t4_drain", 32'(expq.size()), 32'd0);

    // 5: reset mid-burst, then rr_ptr restarts at 0
    do_reset("t5a");
    load(1, 4, 8'h50);
    expect_w(1, 0, 4);
    drive();
    step();
    chk_grant("t5_grant", 4'b0010, 1'b1, 2'd1);
    step();
    step();
    chk("t5_pre_reset_remaining", 32'(expq.size()), 32'd2);
    do_reset("t5b");
    load(1, 4, 8'h60);
    load(2, 4, 8'h70);
    expect_w(1, 0, 4);
    expect_w(2, 0, 4);
    drive();
    step();
    chk_grant("t5_after_rst_grant1", 4'b0010, 1'b1, 2'd1);
    repeat (4) step();
    chk_grant("t5_idle", 4'b0000, 1'b0, 2'd1);
    step();
    chk_grant("t5_grant2", 4'b0100, 1'b1, 2'd2);
    repeat (4) step();
    chk("t5_drain", 32'(expq.size()), 32'd0);

    // 6: wfull high at grant time, first write when wfull falls
    do_reset("t6");
    wfull = 1'b1;
    load(0, 2, 8'h90);
    expect_w(0, 0, 2);
    drive();
    step();
    chk_grant("t6_grant", 4'b0001, 1'b1, 2'd0);
    chk("t6_blocked_winc", 32'(winc), 32'd0);
    repeat (3) begin
      step();
      chk("t6_stall_gnt", 32'(gnt), 32'(4'b0001));
      chk("t6_stall_winc", 32'(winc), 32'd0);
    end
    chk("t6_no_writes_yet", 32'(expq.size()), 32'd2);
    wfull = 1'b0;
    #1;
    chk("t6_first_write_winc", 32'(winc), 32'd1);
    chk("t6_first_write_data", 32'(wdata), 32'h90);
    step();
    step();
    chk_grant("t6_hold", 4'b0001, 1'b1, 2'd0);
    step();
    chk_grant("t6_release", 4'b0000, 1'b0, 2'd0);
    chk("t6_drain", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
